// File: rtl/event_expand_store_gen.sv
// Gearbox from a packed-sample input stream into wide AXI4-Stream words, with
// per-frame expand/raw mode, TLAST flush with exact TKEEP and an output FIFO.
module event_expand_store_gen #(
    parameter int SAMPLE_BITS = 12,
    parameter int LANE_BITS   = 16,
    parameter int IN_WIDTH    = 64,
    parameter int OUT_WIDTH   = 512,
    parameter int FIFO_DEPTH  = 16,
    parameter int SPACE_WORDS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   expand_i,
    input  logic [IN_WIDTH-1:0]    s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic [OUT_WIDTH-1:0]   m_axis_tdata,
    output logic [OUT_WIDTH/8-1:0] m_axis_tkeep,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic                   space_avail_o,
    output logic [15:0]            frame_count_o
);

    localparam int LANES = OUT_WIDTH / LANE_BITS;
    localparam int P     = LANES * SAMPLE_BITS;
    localparam int K_E   = P / IN_WIDTH;
    localparam int K_R   = OUT_WIDTH / IN_WIDTH;
    localparam int KB    = OUT_WIDTH / 8;
    localparam int IW    = (K_R > 1) ? $clog2(K_R) : 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    if ((P % IN_WIDTH) != 0 || LANE_BITS < SAMPLE_BITS ||
        (OUT_WIDTH % IN_WIDTH) != 0 || (OUT_WIDTH % LANE_BITS) != 0) begin : g_bad_params
        $error("event_expand_store_gen: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, FILL, PEND} state_e;

    function automatic logic [KB-1:0] low_mask(input int n);
        logic [KB-1:0] m;
        m = '0;
        for (int b = 0; b < KB; b++) if (b < n) m[b] = 1'b1;
        return m;
    endfunction

    // Flush TKEEP indexed by the 0-based beat on which TLAST arrived
    logic [KB-1:0] keep_e_tab [K_R];
    logic [KB-1:0] keep_r_tab [K_R];
    for (genvar j = 0; j < K_R; j++) begin : g_keep
        assign keep_e_tab[j] = low_mask(((j + 1) * IN_WIDTH / SAMPLE_BITS) * LANE_BITS / 8);
        assign keep_r_tab[j] = low_mask((j + 1) * IN_WIDTH / 8);
    end

    state_e                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [IW-1:0]          cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]   acc_q, acc_d;
    logic [OUT_WIDTH-1:0]   hold_data_q, hold_data_d;
    logic [KB-1:0]          hold_keep_q, hold_keep_d;
    logic                   hold_last_q, hold_last_d;
    logic                   rdy_q;
    logic [AW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]            count_q, count_d;
    logic                   space_q, space_d;
    logic [15:0]            frame_q, frame_d;

    logic [OUT_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [KB-1:0]          fifo_keep_q [FIFO_DEPTH];
    logic                   fifo_last_q [FIFO_DEPTH];

    logic                   beat_fire, cur_mode, last_beat, complete;
    logic                   full, rd_fire, can_wr, wr_en, wr_last;
    logic [IW-1:0]          k_last;
    logic [OUT_WIDTH-1:0]   acc_ins, exp_word, cmp_data, wr_data;
    logic [KB-1:0]          cmp_keep, wr_keep;

    assign s_axis_tready = rdy_q && (state_q != PEND);
    assign beat_fire     = s_axis_tvalid && s_axis_tready;
    // Mode is only taken from expand_i on the first beat of a frame
    assign cur_mode      = (state_q == IDLE) ? expand_i : mode_q;
    assign k_last        = cur_mode ? IW'(K_E - 1) : IW'(K_R - 1);
    assign last_beat     = (cnt_q == k_last);
    assign complete      = beat_fire && (last_beat || s_axis_tlast);

    always_comb begin
        acc_ins = (cnt_q == '0) ? '0 : acc_q;
        acc_ins[int'(cnt_q) * IN_WIDTH +: IN_WIDTH] = s_axis_tdata;
    end

    always_comb begin
        exp_word = '0;
        for (int i = 0; i < LANES; i++)
            exp_word[i * LANE_BITS +: SAMPLE_BITS] = acc_ins[i * SAMPLE_BITS +: SAMPLE_BITS];
    end

    assign cmp_data = cur_mode ? exp_word : acc_ins;
    assign cmp_keep = last_beat ? '1 : (cur_mode ? keep_e_tab[cnt_q] : keep_r_tab[cnt_q]);

    assign m_axis_tvalid = (count_q != '0);
    assign full          = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign rd_fire       = m_axis_tvalid && m_axis_tready;
    assign can_wr        = !full || rd_fire;
    assign wr_en         = ((state_q == PEND) || complete) && can_wr;
    assign wr_data       = (state_q == PEND) ? hold_data_q : cmp_data;
    assign wr_keep       = (state_q == PEND) ? hold_keep_q : cmp_keep;
    assign wr_last       = (state_q == PEND) ? hold_last_q : s_axis_tlast;

    assign m_axis_tdata  = m_axis_tvalid ? fifo_data_q[rptr_q] : '0;
    assign m_axis_tkeep  = m_axis_tvalid ? fifo_keep_q[rptr_q] : '0;
    assign m_axis_tlast  = m_axis_tvalid && fifo_last_q[rptr_q];
    assign space_avail_o = space_q;
    assign frame_count_o = frame_q;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        hold_data_d = hold_data_q;
        hold_keep_d = hold_keep_q;
        hold_last_d = hold_last_q;
        case (state_q)
            IDLE, FILL: begin
                if (beat_fire) begin
                    acc_d  = acc_ins;
                    mode_d = cur_mode;
                    if (complete) begin
                        cnt_d = '0;
                        if (can_wr) begin
                            state_d = s_axis_tlast ? IDLE : FILL;
                        end else begin
                            state_d     = PEND;
                            hold_data_d = cmp_data;
                            hold_keep_d = cmp_keep;
                            hold_last_d = s_axis_tlast;
                        end
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = FILL;
                    end
                end
            end
            PEND:    if (can_wr) state_d = hold_last_q ? IDLE : FILL;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        frame_d = frame_q;
        if (wr_en)   wptr_d = wptr_q + 1'b1;
        if (rd_fire) rptr_d = rptr_q + 1'b1;
        case ({wr_en, rd_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        space_d = (FIFO_DEPTH - int'(count_d)) >= SPACE_WORDS;
        if (wr_en && wr_last) frame_d = frame_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            hold_data_q <= '0;
            hold_keep_q <= '0;
            hold_last_q <= 1'b0;
            rdy_q       <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            space_q     <= 1'b0;
            frame_q     <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            hold_data_q <= hold_data_d;
            hold_keep_q <= hold_keep_d;
            hold_last_q <= hold_last_d;
            rdy_q       <= 1'b1;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            space_q     <= space_d;
            frame_q     <= frame_d;
        end
    end

    // Storage needs no reset: outputs are gated by the FIFO count
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_data_q[wptr_q] <= wr_data;
            fifo_keep_q[wptr_q] <= wr_keep;
            fifo_last_q[wptr_q] <= wr_last;
        end
    end

endmodule

// File: tb/tb_event_expand_store_gen.sv
// Bench for event_expand_store_gen: random and directed frames checked against a
// bit-stream reference model of the expand/raw packing rules.
module tb_event_expand_store_gen;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         expand_i = 1'b0;
    logic [63:0]  s_axis_tdata = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tlast = 1'b0;
    logic         s_axis_tready;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready = 1'b0;
    logic         space_avail_o;
    logic [15:0]  frame_count_o;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
    } word_t;

    word_t       exp_q[$];
    word_t       obs_q[$];
    int          tests = 0;
    int          fails = 0;
    int          rmode = 1;
    logic [15:0] exp_frames = '0;

    event_expand_store_gen dut (
        .clk(clk), .rst_n(rst_n), .expand_i(expand_i),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready), .space_avail_o(space_avail_o),
        .frame_count_o(frame_count_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        word_t w;
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            w.d = m_axis_tdata; w.k = m_axis_tkeep; w.l = m_axis_tlast;
            obs_q.push_back(w);
        end
    end

    // Frame as one flat bit stream: expand words take 384 bits (32 samples of 12),
    // raw words take 512. Keep = whole samples * 2 bytes, or whole bytes in raw.
    function automatic void model_frame(input bit md, input logic [63:0] beats[$]);
        bit    bs[$];
        word_t w;
        int    total, wbits, nw, avail;
        foreach (beats[b]) for (int i = 0; i < 64; i++) bs.push_back(beats[b][i]);
        total = bs.size();
        wbits = md ? 384 : 512;
        nw    = (total + wbits - 1) / wbits;
        for (int n = 0; n < nw; n++) begin
            avail = total - n * wbits;
            if (avail > wbits) avail = wbits;
            w.d = '0; w.k = '0; w.l = (n == nw - 1);
            if (md) begin
                for (int s = 0; s < 32; s++)
                    for (int b = 0; b < 12; b++)
                        if (s * 12 + b < avail) w.d[s * 16 + b] = bs[n * wbits + s * 12 + b];
                for (int by = 0; by < (avail / 12) * 2; by++) w.k[by] = 1'b1;
            end else begin
                for (int b = 0; b < avail; b++) w.d[b] = bs[n * wbits + b];
                for (int by = 0; by < avail / 8; by++) w.k[by] = 1'b1;
            end
            exp_q.push_back(w);
        end
    endfunction

    function automatic logic [63:0] ramp_beat(input int b);
        logic [63:0] r;
        int idx, s;
        for (int i = 0; i < 64; i++) begin
            idx  = b * 64 + i;
            s    = idx / 12;
            r[i] = s[idx % 12];
        end
        return r;
    endfunction

    task automatic send_frame(input bit md, input logic [63:0] beats[$], input int flip_at,
                              output int stalls);
        bit ok;
        int n;
        model_frame(md, beats);
        exp_frames++;
        expand_i = md;
        stalls   = 0;
        foreach (beats[b]) begin
            if (b == flip_at) expand_i = ~md;
            s_axis_tdata  = beats[b];
            s_axis_tlast  = (b == beats.size() - 1);
            s_axis_tvalid = 1'b1;
            n = 0;
            do begin
                @(negedge clk); ok = s_axis_tready;
                @(posedge clk); #1;
                if (!ok) begin stalls++; n++; end
            end while (!ok && n < 1000);
            if (!ok) begin
                tests++; fails++;
                $display("FAIL send_beat timeout beat=%0d tready=%b required 1", b, s_axis_tready);
                break;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int c = 0;
        while (obs_q.size() < n && c < 3000) begin @(posedge clk); c++; end
        #1;
        tests++;
        if (obs_q.size() < n) begin
            fails++;
            $display("FAIL wait_words got=%0d required=%0d", obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests += 7;
        if (s_axis_tready !== 1'b0) begin fails++; $display("FAIL rst_tready got=%b required 0", s_axis_tready); end
        if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid got=%b required 0", m_axis_tvalid); end
        if (m_axis_tlast !== 1'b0) begin fails++; $display("FAIL rst_tlast got=%b required 0", m_axis_tlast); end
        if (m_axis_tkeep !== '0) begin fails++; $display("FAIL rst_tkeep got=%h required 0", m_axis_tkeep); end
        if (m_axis_tdata !== '0) begin fails++; $display("FAIL rst_tdata got=%h required 0", m_axis_tdata); end
        if (space_avail_o !== 1'b0) begin fails++; $display("FAIL rst_space got=%b required 0", space_avail_o); end
        if (frame_count_o !== 16'd0) begin fails++; $display("FAIL rst_frames got=%0d required 0", frame_count_o); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        tests += 2;
        if (s_axis_tready !== 1'b1) begin fails++; $display("FAIL post_rst_tready got=%b required 1", s_axis_tready); end
        if (space_avail_o !== 1'b1) begin fails++; $display("FAIL post_rst_space got=%b required 1", space_avail_o); end
    endtask

    task automatic test_expand_ramp();
        logic [63:0] bq[$];
        word_t e, o;
        int st;
        bit bad;
        rmode = 1;
        for (int b = 0; b < 6; b++) bq.push_back(ramp_beat(b));
        send_frame(1'b1, bq, -1, st);
        wait_words(1);
        if (obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            bad = 1'b0;
            for (int i = 0; i < 32; i++) if (o.d[i * 16 +: 16] !== 16'(i)) bad = 1'b1;
            tests += 3;
            if (bad) begin fails++; $display("FAIL ramp_lanes got=%h", o.d); end
            if (o.k !== '1 || o.l !== 1'b1) begin fails++; $display("FAIL ramp_keep_last got=%h/%b required all-ones/1", o.k, o.l); end
            if (o.d !== e.d) begin fails++; $display("FAIL ramp_model got=%h required=%h", o.d, e.d); end
        end
        tests++;
        if (frame_count_o !== 16'd1) begin fails++; $display("FAIL ramp_frames got=%0d required 1", frame_count_o); end
    endtask

    task automatic test_raw();
        logic [63:0] bq[$];
        word_t e, o;
        int st;
        rmode = 1;
        for (int b = 0; b < 8; b++) bq.push_back({$urandom, $urandom});
        send_frame(1'b0, bq, -1, st);
        wait_words(1);
        if (obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests += 2;
            if (o.k !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL raw_keep got=%h required all-ones", o.k); end
            if (o.d !== e.d || o.l !== e.l) begin fails++; $display("FAIL raw_word got=%h/%b required=%h/%b", o.d, o.l, e.d, e.l); end
        end
    endtask

    task automatic test_flush();
        logic [63:0] bq[$];
        word_t e, o;
        int st;
        rmode = 1;
        for (int b = 0; b < 2; b++) bq.push_back(ramp_beat(b));
        send_frame(1'b1, bq, -1, st);
        wait_words(1);
        if (obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests += 3;
            if (o.k !== 64'h0000_0000_000F_FFFF) begin fails++; $display("FAIL flush_keep got=%h required 000fffff", o.k); end
            if (o.d[511:176] !== '0) begin fails++; $display("FAIL flush_upper got=%h required 0", o.d[511:176]); end
            if (o.d !== e.d || o.l !== 1'b1) begin fails++; $display("FAIL flush_word got=%h/%b required=%h/1", o.d, o.l, e.d); end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] bq[$];
        word_t e, o;
        int st, tot;
        rmode = 1;
        tot = 0;
        for (int f = 0; f < 2; f++) begin
            bq.delete();
            for (int b = 0; b < 12; b++) bq.push_back({$urandom, $urandom});
            send_frame(1'b1, bq, -1, st);
            tot += st;
        end
        tests++;
        if (tot != 0) begin fails++; $display("FAIL b2b_stalls got=%0d required 0", tot); end
        wait_words(4);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++;
            if (o.d !== e.d || o.k !== e.k || o.l !== e.l) begin fails++; $display("FAIL b2b_word got=%h/%h/%b required=%h/%h/%b", o.d, o.k, o.l, e.d, e.k, e.l); end
        end
    endtask

    task automatic test_mode_toggle();
        logic [63:0] bq[$];
        word_t e, o;
        int st;
        rmode = 1;
        for (int b = 0; b < 6; b++) bq.push_back({$urandom, $urandom});
        send_frame(1'b1, bq, 2, st);
        bq.delete();
        for (int b = 0; b < 8; b++) bq.push_back({$urandom, $urandom});
        send_frame(1'b0, bq, 3, st);
        wait_words(2);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++;
            if (o.d !== e.d || o.k !== e.k || o.l !== e.l) begin fails++; $display("FAIL toggle_word got=%h/%h/%b required=%h/%h/%b", o.d, o.k, o.l, e.d, e.k, e.l); end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0]  bq[$];
        logic [511:0] held;
        word_t e, o;
        int st;
        rmode = 0;
        @(posedge clk); #1;
        for (int b = 0; b < 17 * 6; b++) bq.push_back({$urandom, $urandom});
        send_frame(1'b1, bq, -1, st);
        @(posedge clk); #1;
        tests += 4;
        if (s_axis_tready !== 1'b0) begin fails++; $display("FAIL bp_tready got=%b required 0", s_axis_tready); end
        if (space_avail_o !== 1'b0) begin fails++; $display("FAIL bp_space got=%b required 0", space_avail_o); end
        if (m_axis_tvalid !== 1'b1) begin fails++; $display("FAIL bp_tvalid got=%b required 1", m_axis_tvalid); end
        if (obs_q.size() != 0) begin fails++; $display("FAIL bp_leak got=%0d required 0", obs_q.size()); end
        held = m_axis_tdata;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (m_axis_tdata !== held) begin fails++; $display("FAIL bp_stable got=%h required=%h", m_axis_tdata, held); end
        rmode = 1;
        wait_words(17);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++;
            if (o.d !== e.d || o.k !== e.k || o.l !== e.l) begin fails++; $display("FAIL bp_word got=%h/%h/%b required=%h/%h/%b", o.d, o.k, o.l, e.d, e.k, e.l); end
        end
        tests += 2;
        if (s_axis_tready !== 1'b1) begin fails++; $display("FAIL bp_resume got=%b required 1", s_axis_tready); end
        if (space_avail_o !== 1'b1) begin fails++; $display("FAIL bp_space_back got=%b required 1", space_avail_o); end
    endtask

    task automatic test_random();
        logic [63:0] bq[$];
        word_t e, o;
        int st, len, nexp;
        bit md;
        rmode = 2;
        for (int f = 0; f < 10; f++) begin
            bq.delete();
            md  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 20);
            for (int b = 0; b < len; b++) bq.push_back({$urandom, $urandom});
            send_frame(md, bq, -1, st);
        end
        nexp = exp_q.size();
        wait_words(nexp);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++;
            if (o.d !== e.d || o.k !== e.k || o.l !== e.l) begin fails++; $display("FAIL rand_word got=%h/%h/%b required=%h/%h/%b", o.d, o.k, o.l, e.d, e.k, e.l); end
        end
        tests++;
        if (frame_count_o !== exp_frames) begin fails++; $display("FAIL rand_frames got=%0d required=%0d", frame_count_o, exp_frames); end
        rmode = 1;
    endtask

    task automatic test_midreset();
        logic [63:0] bq[$];
        word_t e, o;
        int st;
        rmode = 1;
        expand_i = 1'b1;
        s_axis_tvalid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            s_axis_tdata = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        tests += 5;
        if (s_axis_tready !== 1'b0) begin fails++; $display("FAIL mid_rst_tready got=%b required 0", s_axis_tready); end
        if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL mid_rst_tvalid got=%b required 0", m_axis_tvalid); end
        if (m_axis_tdata !== '0) begin fails++; $display("FAIL mid_rst_tdata got=%h required 0", m_axis_tdata); end
        if (frame_count_o !== 16'd0) begin fails++; $display("FAIL mid_rst_frames got=%0d required 0", frame_count_o); end
        if (space_avail_o !== 1'b0) begin fails++; $display("FAIL mid_rst_space got=%b required 0", space_avail_o); end
        repeat (2) @(posedge clk);
        exp_q.delete(); obs_q.delete(); exp_frames = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int b = 0; b < 6; b++) bq.push_back({$urandom, $urandom});
        send_frame(1'b1, bq, -1, st);
        wait_words(1);
        repeat (10) @(posedge clk);
        #1;
        tests++;
        if (obs_q.size() != 1) begin fails++; $display("FAIL mid_rst_count got=%0d required 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++;
            if (o.d !== e.d || o.k !== e.k || o.l !== e.l) begin fails++; $display("FAIL mid_rst_word got=%h/%h/%b required=%h/%h/%b", o.d, o.k, o.l, e.d, e.k, e.l); end
        end
        tests++;
        if (frame_count_o !== 16'd1) begin fails++; $display("FAIL mid_rst_frames_after got=%0d required 1", frame_count_o); end
    endtask

    initial begin
        test_reset();
        test_expand_ramp();
        test_raw();
        test_flush();
        test_back_to_back();
        test_mode_toggle();
        test_backpressure();
        test_random();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
